// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl -- scan scheduler for a multiplexed seven-segment display.
//
// Holds two digit banks: a shadow bank written through a valid/ready port and
// an active bank that drives the display. A commit request copies the whole
// shadow bank into the active bank at the next frame end, so a frame never
// shows a mix of old and new digits. Brightness is a 16-phase PWM per digit slot.
//
// Optional feature macro: GHOST_BLANK_EN. When it is defined, the anodes are
// forced off for the first BLANK_CYCLES cycles of every slot (anti-ghosting).
//
// Ports:
//   CLK_12_MHZ      system clock
//   rst_n           asynchronous reset, active low
//   wr_valid        shadow write request
//   wr_ready        write accepted when wr_valid && wr_ready (low while a commit is pending)
//   wr_addr         digit index; indices >= SEGMENTS are accepted and dropped
//   wr_data         [3:0] hex, [4] dp, [5] blank
//   commit          1-cycle pulse: copy shadow to active at the next frame end
//   brightness      0 = 1/16 duty ... 15 = full duty, sampled at slot start
//   an              anode enables, active low, registered
//   hex_out         hex nibble of the current digit, registered
//   dp_out          decimal point of the current digit, registered
//   commit_pending  commit requested, not yet applied
//   frame_tick      1-cycle pulse after the last slot of a frame ends
module disp_scan_ctrl #(
  parameter int unsigned SEGMENTS     = 6,
  parameter int unsigned PWM_DIV      = 125,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                CLK_12_MHZ,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [2:0]          wr_addr,
  input  logic [5:0]          wr_data,
  input  logic                commit,
  input  logic [3:0]          brightness,
  output logic [SEGMENTS-1:0] an,
  output logic [3:0]          hex_out,
  output logic                dp_out,
  output logic                commit_pending,
  output logic                frame_tick
);

  localparam int unsigned   DW         = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(PWM_DIV - 1);
  localparam logic [DW-1:0] BLANK_N    = DW'(BLANK_CYCLES);
  localparam logic [2:0]    DIGIT_LAST = 3'(SEGMENTS - 1);
  localparam logic [3:0]    SEG_N      = 4'(SEGMENTS);
  // Reset/empty entry: hex 0, dp 0, blanked.
  localparam logic [5:0]    ENTRY_RST  = 6'b100000;

`ifdef GHOST_BLANK_EN
  localparam bit GHOST_EN = 1'b1;
`else
  localparam bit GHOST_EN = 1'b0;
`endif

  logic [DW-1:0] div_cnt;
  logic [3:0]    pwm_ph;
  logic [2:0]    digit;
  logic [3:0]    bri_q;

  logic [5:0] shadow [SEGMENTS];
  logic [5:0] active [SEGMENTS];

  logic                slot_start;
  logic                div_wrap;
  logic                slot_end;
  logic                frame_end;
  logic                dead_time;
  logic                lit;
  logic                wr_accept;
  logic [5:0]          cur;
  logic [SEGMENTS-1:0] an_next;

  assign wr_ready = ~commit_pending;

  always_comb begin
    slot_start = (div_cnt == '0) && (pwm_ph == '0);
    div_wrap   = (div_cnt == DIV_LAST);
    slot_end   = div_wrap && (pwm_ph == 4'hF);
    frame_end  = slot_end && (digit == DIGIT_LAST);
    cur        = active[digit];
    dead_time  = GHOST_EN && (pwm_ph == '0) && (div_cnt < BLANK_N);
    lit        = (pwm_ph <= bri_q) && !cur[5] && !dead_time;
    wr_accept  = wr_valid && wr_ready && ({1'b0, wr_addr} < SEG_N);
    an_next        = '1;
    an_next[digit] = ~lit;
  end

  // Scan counters: div_cnt -> pwm_ph -> digit.
  always_ff @(posedge CLK_12_MHZ or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pwm_ph  <= '0;
      digit   <= '0;
      bri_q   <= '0;
    end else begin
      if (slot_start) begin
        bri_q <= brightness;
      end
      if (div_wrap) begin
        div_cnt <= '0;
        pwm_ph  <= pwm_ph + 4'd1;
        if (pwm_ph == 4'hF) begin
          digit <= (digit == DIGIT_LAST) ? '0 : digit + 3'd1;
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // Commit handshake. A commit seen on the frame-end cycle while nothing is
  // pending arms the request for the following frame end.
  always_ff @(posedge CLK_12_MHZ or negedge rst_n) begin
    if (!rst_n) begin
      commit_pending <= 1'b0;
    end else if (frame_end && commit_pending) begin
      commit_pending <= 1'b0;
    end else if (commit && !commit_pending) begin
      commit_pending <= 1'b1;
    end
  end

  // Register banks. Writes are blocked while a commit is pending, so the
  // copy on frame end always sees a stable shadow bank.
  always_ff @(posedge CLK_12_MHZ or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SEGMENTS; i++) begin
        shadow[i] <= ENTRY_RST;
        active[i] <= ENTRY_RST;
      end
    end else begin
      if (wr_accept) begin
        shadow[wr_addr] <= wr_data;
      end
      if (frame_end && commit_pending) begin
        for (int unsigned i = 0; i < SEGMENTS; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  // Display outputs, one cycle behind the counters.
  always_ff @(posedge CLK_12_MHZ or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      hex_out    <= '0;
      dp_out     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      hex_out    <= cur[3:0];
      dp_out     <= cur[4];
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl (SEGMENTS=6, PWM_DIV=125).
// A time-based reference model predicts every output cycle; predictions are
// queued at the clock edge and compared at the following falling edge.
// A stimulus table drives writes/commits/brightness at fixed scan times.
module tb_disp_scan_ctrl;

  localparam int SEG  = 6;
  localparam int SLOT = 2000;
  localparam int FRAME = SEG * SLOT;
`ifdef GHOST_BLANK_EN
  localparam int BLANK = 8;
`else
  localparam int BLANK = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_valid;
  logic           wr_ready;
  logic [2:0]     wr_addr;
  logic [5:0]     wr_data;
  logic           commit;
  logic [3:0]     brightness;
  logic [SEG-1:0] an;
  logic [3:0]     hex_out;
  logic           dp_out;
  logic           commit_pending;
  logic           frame_tick;

  disp_scan_ctrl #(.SEGMENTS(6), .PWM_DIV(125), .BLANK_CYCLES(8)) dut (
    .CLK_12_MHZ     (clk),
    .rst_n          (rst_n),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .commit         (commit),
    .brightness     (brightness),
    .an             (an),
    .hex_out        (hex_out),
    .dp_out         (dp_out),
    .commit_pending (commit_pending),
    .frame_tick     (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int             t;
    logic [SEG-1:0] an;
    logic [3:0]     hex;
    logic           dp;
    logic           tick;
    logic           ready;
  } exp_t;
  exp_t sbq[$];

  // Reference model state
  logic [5:0] m_active [SEG];
  logic [5:0] m_shadow [SEG];
  bit         m_pending;
  int         m_t;
  int         m_bri;

  int ticks_first = 0;
  int lit_full    = 0;
  int lit_half    = 0;

  task automatic model_reset();
    for (int i = 0; i < SEG; i++) begin
      m_active[i] = 6'b100000;
      m_shadow[i] = 6'b100000;
    end
    m_pending = 0;
    m_t       = 0;
    m_bri     = 0;
  endtask

  task automatic model_step();
    exp_t e;
    int   slot, d, ph, dv;
    bit   lit, fe;
    if (!rst_n) begin
      model_reset();
      e.t = -1; e.an = '1; e.hex = 4'h0; e.dp = 1'b0; e.tick = 1'b0; e.ready = 1'b1;
    end else begin
      slot = m_t % SLOT;
      d    = (m_t / SLOT) % SEG;
      ph   = slot / 125;
      dv   = slot % 125;
      if (slot == 0) m_bri = int'(brightness);
      lit = (ph <= m_bri) && !m_active[d][5];
      if (ph == 0 && dv < BLANK) lit = 0;
      fe = ((m_t % FRAME) == FRAME - 1);
      e.t     = m_t;
      e.an    = '1;
      e.an[d] = !lit;
      e.hex   = m_active[d][3:0];
      e.dp    = m_active[d][4];
      e.tick  = fe;
      if (wr_valid && !m_pending && int'(wr_addr) < SEG) m_shadow[wr_addr] = wr_data;
      if (fe && m_pending) begin
        for (int i = 0; i < SEG; i++) m_active[i] = m_shadow[i];
        m_pending = 0;
      end else if (commit && !m_pending) begin
        m_pending = 1;
      end
      e.ready = !m_pending;
      m_t++;
    end
    sbq.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Scoreboard: compare the prediction made at the last rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (an !== e.an || hex_out !== e.hex || dp_out !== e.dp ||
            frame_tick !== e.tick || wr_ready !== e.ready) begin
          failures++;
          $display("FAIL scan t=%0d an=%b/%b hex=%h/%h dp=%b/%b tick=%b/%b ready=%b/%b (actual/expected)",
                   e.t, an, e.an, hex_out, e.hex, dp_out, e.dp, frame_tick, e.tick, wr_ready, e.ready);
        end
        if (e.tick && e.t >= 0 && e.t < 2 * FRAME) ticks_first++;
        if (e.t >= 3 * FRAME && e.t < 3 * FRAME + SLOT && an[0] == 1'b0) lit_full++;
        if (e.t >= 4 * FRAME && e.t < 4 * FRAME + SLOT && an[0] == 1'b0) lit_half++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_until(input int target);
    while (m_t < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int         at;
    logic       valid;
    logic [2:0] addr;
    logic [5:0] data;
    logic       cmt;
    logic [3:0] bri;
    logic       rdy;
  } step_t;
  step_t tbl[12];

  task automatic apply(input int i);
    wait_until(tbl[i].at);
    chk($sformatf("wr_ready_step%0d", i), int'(wr_ready), int'(tbl[i].rdy));
    wr_valid   = tbl[i].valid;
    wr_addr    = tbl[i].addr;
    wr_data    = tbl[i].data;
    commit     = tbl[i].cmt;
    brightness = tbl[i].bri;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    commit   = 1'b0;
  endtask

  initial begin
    int n;
    //           at       valid addr  data   commit bri    ready
    tbl[0]  = '{24010,    1'b1, 3'd0, 6'h0A, 1'b0, 4'd15, 1'b1};
    tbl[1]  = '{24011,    1'b1, 3'd5, 6'h13, 1'b0, 4'd15, 1'b1};
    tbl[2]  = '{24012,    1'b1, 3'd7, 6'h3F, 1'b1, 4'd15, 1'b1};
    tbl[3]  = '{24020,    1'b1, 3'd1, 6'h05, 1'b1, 4'd15, 1'b0};
    tbl[4]  = '{24030,    1'b0, 3'd0, 6'h00, 1'b1, 4'd15, 1'b0};
    tbl[5]  = '{36010,    1'b1, 3'd1, 6'h05, 1'b0, 4'd15, 1'b1};
    tbl[6]  = '{36011,    1'b0, 3'd0, 6'h00, 1'b1, 4'd15, 1'b1};
    tbl[7]  = '{36500,    1'b0, 3'd0, 6'h00, 1'b0, 4'd7,  1'b0};
    tbl[8]  = '{48100,    1'b1, 3'd2, 6'h07, 1'b0, 4'd7,  1'b1};
    tbl[9]  = '{59999,    1'b0, 3'd0, 6'h00, 1'b1, 4'd7,  1'b1};
    tbl[10] = '{60005,    1'b1, 3'd3, 6'h2F, 1'b0, 4'd7,  1'b0};
    tbl[11] = '{78100,    1'b1, 3'd4, 6'h01, 1'b1, 4'd7,  1'b1};

    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; brightness = 4'd15;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_an", int'(an), 63);
    chk("reset_ready", int'(wr_ready), 1);
    chk("reset_pending", int'(commit_pending), 0);
    #6 rst_n = 1'b1;

    // Two idle frames with every entry blank.
    wait_until(24005);
    chk("frame_ticks_idle", ticks_first, 2);

    for (int i = 0; i < 5; i++) apply(i);

    // Pending commit must block writes until the frame end clears it.
    n = 0;
    while (frame_tick !== 1'b1 && n < 13000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_tick_timeout", int'(n < 13000), 1);
    chk("ready_after_tick", int'(wr_ready), 1);
    chk("pending_after_tick", int'(commit_pending), 0);

    for (int i = 5; i < 12; i++) apply(i);

    chk("duty_full", lit_full, SLOT - BLANK);
    chk("duty_half", lit_half, SLOT / 2 - BLANK);

    // Asynchronous reset in the middle of digit 3's slot.
    wait_until(78500);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", int'(an), 63);
    chk("async_rst_hex", int'(hex_out), 0);
    chk("async_rst_dp", int'(dp_out), 0);
    chk("async_rst_pending", int'(commit_pending), 0);
    repeat (3) @(posedge clk);
    #7 rst_n = 1'b1;
    wait_until(FRAME + 100);
    chk("pending_lost", int'(commit_pending), 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(150000 * 10);
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
